// File: rtl/urv_div_seq_if.sv
// Execute-stage <-> divide sequencer signal bundle.
// Master is the pipeline side, slave is the divider.
interface urv_div_seq_if;
    logic        x_valid_i;
    logic        x_is_divide_i;
    logic [2:0]  x_fun_i;
    logic [31:0] x_rs1_value_i;
    logic [31:0] x_rs2_value_i;
    logic        x_stall_i;
    logic        x_kill_i;
    logic        x_stall_req_o;
    logic        x_done_o;
    logic [31:0] x_rd_value_o;
    logic        x_busy_o;

    modport master (
        output x_valid_i, x_is_divide_i, x_fun_i,
        output x_rs1_value_i, x_rs2_value_i,
        output x_stall_i, x_kill_i,
        input  x_stall_req_o, x_done_o,
        input  x_rd_value_o, x_busy_o
    );

    modport slave (
        input  x_valid_i, x_is_divide_i, x_fun_i,
        input  x_rs1_value_i, x_rs2_value_i,
        input  x_stall_i, x_kill_i,
        output x_stall_req_o, x_done_o,
        output x_rd_value_o, x_busy_o
    );
endinterface

// File: rtl/urv_div_seq.sv
// Iterative restoring divide/remainder sequencer for uRV.
// Produces RV32M results, stalling the pipeline while busy.
module urv_div_seq #(
    parameter int g_bits_per_cycle = 1,
    parameter bit g_fast_div0      = 1
) (
    input logic          clk_i,
    input logic          rst_n_i,
    urv_div_seq_if.slave bus
);
    localparam int ITER_LEN = 32 / g_bits_per_cycle;

    typedef enum logic [2:0] {
        IDLE, PREP, ITER, FIX, DONE
    } state_t;

    state_t      state;
    logic [2:0]  fun;
    logic [31:0] a_raw;
    logic [31:0] b_raw;
    logic [31:0] quo;
    logic [31:0] rem;
    logic [31:0] dvs;
    logic [5:0]  cnt;
    logic        neg_q;
    logic        neg_r;
    logic        done;
    logic [31:0] rd_value;

    logic        start;
    logic        sgn_in;
    logic        na;
    logic        nb;
    logic [32:0] sh;
    logic [31:0] r_it;
    logic [31:0] q_it;
    logic [31:0] result;

    assign start = (state == IDLE) & bus.x_valid_i
                 & bus.x_is_divide_i & ~bus.x_kill_i;

    assign bus.x_stall_req_o = ~bus.x_kill_i & (start
                             | state == PREP
                             | state == ITER
                             | state == FIX);
    assign bus.x_done_o     = done;
    assign bus.x_rd_value_o = rd_value;
    assign bus.x_busy_o     = (state != IDLE);

    assign sgn_in = ~fun[0];
    assign na     = sgn_in & a_raw[31];
    assign nb     = sgn_in & b_raw[31];

    // Restoring steps for one ITER cycle.
    always_comb begin
        r_it = rem;
        q_it = quo;
        sh   = '0;
        for (int i = 0; i < g_bits_per_cycle; i++) begin
            sh   = {r_it, q_it[31]};
            q_it = {q_it[30:0], 1'b0};
            if (sh >= {1'b0, dvs}) begin
                sh      = sh - {1'b0, dvs};
                q_it[0] = 1'b1;
            end
            r_it = sh[31:0];
        end
    end

    // Sign correction, forced cases and quotient/remainder select.
    always_comb begin
        logic [31:0] qf;
        logic [31:0] rf;
        qf = neg_q ? -quo : quo;
        rf = neg_r ? -rem : rem;
        if (b_raw == 32'h0) begin
            qf = 32'hFFFF_FFFF;
            rf = a_raw;
        end else if (sgn_in && a_raw == 32'h8000_0000
                     && b_raw == 32'hFFFF_FFFF) begin
            qf = 32'h8000_0000;
            rf = 32'h0;
        end
        result = fun[1] ? rf : qf;
    end

    // Sequencer FSM with registered done/result.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= IDLE;
            fun      <= '0;
            a_raw    <= '0;
            b_raw    <= '0;
            quo      <= '0;
            rem      <= '0;
            dvs      <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            done     <= 1'b0;
            rd_value <= '0;
        end else if (bus.x_kill_i) begin
            state <= IDLE;
            done  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        fun   <= bus.x_fun_i;
                        a_raw <= bus.x_rs1_value_i;
                        b_raw <= bus.x_rs2_value_i;
                        state <= PREP;
                    end
                end
                PREP: begin
                    quo   <= na ? -a_raw : a_raw;
                    dvs   <= nb ? -b_raw : b_raw;
                    rem   <= '0;
                    neg_q <= na ^ nb;
                    neg_r <= na;
                    cnt   <= 6'(ITER_LEN);
                    if (g_fast_div0 && b_raw == 32'h0)
                        state <= FIX;
                    else
                        state <= ITER;
                end
                ITER: begin
                    quo <= q_it;
                    rem <= r_it;
                    cnt <= cnt - 6'd1;
                    if (cnt == 6'd1)
                        state <= FIX;
                end
                FIX: begin
                    rd_value <= result;
                    done     <= 1'b1;
                    state    <= DONE;
                end
                DONE: begin
                    if (!bus.x_stall_i) begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_urv_div_seq.sv
// Directed scoreboard bench for urv_div_seq.
// Default build: 1 bit/cycle, fast divide-by-zero.
module tb_urv_div_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    logic [31:0] sb[$];
    logic [31:0] last_val;

    urv_div_seq_if bus ();

    urv_div_seq dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(
        input logic [2:0] f,
        input logic [31:0] a,
        input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sbv;
        sa  = a;
        sbv = b;
        if (b == 32'h0)
            return f[1] ? a : 32'hFFFF_FFFF;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return f[1] ? 32'h0 : 32'h8000_0000;
        case (f)
            3'b100:  return 32'(sa / sbv);
            3'b101:  return a / b;
            3'b110:  return 32'(sa % sbv);
            default: return a % b;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_start(input logic [2:0] f,
                               input logic [31:0] a,
                               input logic [31:0] b);
        bus.x_valid_i     = 1'b1;
        bus.x_is_divide_i = 1'b1;
        bus.x_fun_i       = f;
        bus.x_rs1_value_i = a;
        bus.x_rs2_value_i = b;
    endtask

    // Called in an IDLE cycle, #1 after a rising edge.
    task automatic do_op(input string tag,
                         input logic [2:0] f,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         input int lat,
                         input int hold);
        int   n;
        logic got;
        logic stall_ok;
        logic [31:0] exp;
        drive_start(f, a, b);
        sb.push_back(model(f, a, b));
        #1;
        chk({tag, "_start_stall"}, 32'(bus.x_stall_req_o), 32'd1);
        n        = 0;
        got      = 1'b0;
        stall_ok = 1'b1;
        while (n < 100 && !got) begin
            tick();
            n++;
            if (n == 1)
                bus.x_valid_i = 1'b0;
            if (bus.x_done_o)
                got = 1'b1;
            else
                stall_ok &= bus.x_stall_req_o & bus.x_busy_o;
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_latency"}, n, lat);
        chk({tag, "_stall_busy"}, 32'(stall_ok), 32'd1);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
        chk({tag, "_value"}, bus.x_rd_value_o, exp);
        chk({tag, "_no_stall_done"},
            32'(bus.x_stall_req_o), 32'd0);
        if (hold > 0) begin
            bus.x_stall_i = 1'b1;
            for (int i = 0; i < hold; i++) begin
                tick();
                chk({tag, "_hold_done"}, 32'(bus.x_done_o), 32'd1);
                chk({tag, "_hold_val"}, bus.x_rd_value_o, exp);
            end
            bus.x_stall_i = 1'b0;
        end
        tick();
        chk({tag, "_done_drop"}, 32'(bus.x_done_o), 32'd0);
        chk({tag, "_idle"}, 32'(bus.x_busy_o), 32'd0);
        chk({tag, "_val_kept"}, bus.x_rd_value_o, exp);
        last_val = exp;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.x_valid_i     = 1'b0;
        bus.x_is_divide_i = 1'b0;
        bus.x_fun_i       = 3'b000;
        bus.x_rs1_value_i = '0;
        bus.x_rs2_value_i = '0;
        bus.x_stall_i     = 1'b0;
        bus.x_kill_i      = 1'b0;
        #12;
        chk("rst_done", 32'(bus.x_done_o), 32'd0);
        chk("rst_busy", 32'(bus.x_busy_o), 32'd0);
        chk("rst_val", bus.x_rd_value_o, 32'd0);
        chk("rst_stall", 32'(bus.x_stall_req_o), 32'd0);
        rst_n = 1'b1;
        tick();

        do_op("divu_100_7", 3'b101, 32'd100, 32'd7, 35, 0);
        do_op("remu_100_7", 3'b101 | 3'b010, 32'd100, 32'd7, 35, 0);
        do_op("div_m7_2", 3'b100, -32'sd7, 32'd2, 35, 0);
        do_op("rem_m7_2", 3'b110, -32'sd7, 32'd2, 35, 0);
        do_op("rem_7_m2", 3'b110, 32'd7, -32'sd2, 35, 0);
        do_op("div_by0", 3'b100, 32'h1234, 32'h0, 3, 0);
        do_op("rem_by0", 3'b110, 32'h1234, 32'h0, 3, 0);
        do_op("remu_by0", 3'b111, 32'h1234, 32'h0, 3, 0);
        do_op("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 35, 0);
        do_op("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 35, 0);
        do_op("divu_ovf", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 35, 0);

        // Kill mid-operation, then restart right away.
        drive_start(3'b101, 32'd50, 32'd5);
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.x_valid_i = 1'b0;
        end
        bus.x_kill_i = 1'b1;
        #1;
        chk("kill_stall_drop", 32'(bus.x_stall_req_o), 32'd0);
        tick();
        bus.x_kill_i = 1'b0;
        chk("kill_idle", 32'(bus.x_busy_o), 32'd0);
        chk("kill_no_done", 32'(bus.x_done_o), 32'd0);
        chk("kill_val_kept", bus.x_rd_value_o, last_val);
        do_op("divu_9_3", 3'b101, 32'd9, 32'd3, 35, 0);

        // Kill together with a start request is not a start.
        drive_start(3'b101, 32'd8, 32'd2);
        bus.x_kill_i = 1'b1;
        #1;
        chk("killstart_stall", 32'(bus.x_stall_req_o), 32'd0);
        tick();
        bus.x_kill_i  = 1'b0;
        bus.x_valid_i = 1'b0;
        chk("killstart_idle", 32'(bus.x_busy_o), 32'd0);

        // Downstream stall holds the result in DONE.
        do_op("stall_hold", 3'b100, 32'd1000, -32'sd33, 35, 4);

        for (int k = 0; k < 6; k++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 28);
            if (rb == 32'h0)
                rb = 32'd3;
            rf = {1'b1, 2'($urandom_range(0, 3))};
            do_op("rand", rf, ra, rb, 35, 0);
        end

        // Reset mid-operation.
        drive_start(3'b101, 32'd77, 32'd7);
        for (int i = 0; i < 20; i++) begin
            tick();
            bus.x_valid_i = 1'b0;
        end
        rst_n = 1'b0;
        #1;
        chk("mid_rst_done", 32'(bus.x_done_o), 32'd0);
        chk("mid_rst_busy", 32'(bus.x_busy_o), 32'd0);
        chk("mid_rst_val", bus.x_rd_value_o, 32'd0);
        chk("mid_rst_stall", 32'(bus.x_stall_req_o), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.x_done_o)
                chk("mid_rst_spurious", 32'(bus.x_done_o), 32'd0);
        end
        chk("mid_rst_idle", 32'(bus.x_busy_o), 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/urv_div_seq.md
Name: urv_div_seq

Overview:
- Multi-cycle sequencer for the integer divide/remainder path of the uRV execute stage.
- Accepts divide operations flagged by decode (is-divide, 3-bit function) with operands from the register file.
- Runs an iterative restoring divider under an FSM and stalls the pipeline while busy.
- Returns the RV32M-compliant result to the writeback mux (rd source DIVIDE).

Parameters:
g_bits_per_cycle, 1, quotient bits resolved per ITER cycle; legal values 1 or 2; ITER length = 32/g_bits_per_cycle cycles.
g_fast_div0, 1, when 1 a zero divisor skips ITER (PREP->FIX directly); when 0 it runs the full ITER length.

Ports:
clk_i  in  1  core clock.
rst_n_i  in  1  asynchronous, active-low reset.
x_valid_i  in  1  operation presented in execute stage is valid.
x_is_divide_i  in  1  decoded DIV/DIVU/REM/REMU.
x_fun_i  in  3  funct3: 100 DIV, 101 DIVU, 110 REM, 111 REMU.
x_rs1_value_i  in  32  dividend.
x_rs2_value_i  in  32  divisor.
x_stall_i  in  1  downstream stall; holds result in DONE.
x_kill_i  in  1  pipeline flush; aborts operation.
x_stall_req_o  out  1  request pipeline stall while a divide is in progress.
x_done_o  out  1  result valid.
x_rd_value_o  out  32  quotient or remainder.
x_busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset, asynchronous: state=IDLE; x_done_o=0; x_busy_o=0; x_rd_value_o=0; iteration counter=0; internal quotient, remainder and divisor registers=0.
- States: IDLE, PREP, ITER, FIX, DONE.
- start = IDLE & x_valid_i & x_is_divide_i & !x_kill_i. Operands and funct3 are sampled on the start cycle only.
- x_stall_req_o = start | (state in PREP, ITER, FIX). Combinational, so it is asserted in the start cycle itself. It is low in DONE and IDLE.
- IDLE -> PREP on start.
- PREP:
  - Signed ops (funct3[0]=0): latch sign flags; take absolute values of both operands.
  - Load counter = 32/g_bits_per_cycle.
  - Next state: FIX if divisor==0 and g_fast_div0=1, else ITER.
- ITER:
  - Per cycle, g_bits_per_cycle restoring steps: shift {rem,quo} left by 1; if rem>=divisor then rem-=divisor and quo[0]=1.
  - Use a 33-bit subtract.
  - Decrement the counter; move to FIX when the counter reaches 1.
- FIX: sign-correct and select the result.
  - Quotient is negated if the operand signs differ (signed only).
  - Remainder takes the sign of the dividend (signed only).
  - funct3[1] selects remainder (1) or quotient (0).
- Forced results, taking priority over the computed value:
  - divisor==0: quotient=0xFFFFFFFF; remainder=dividend (original, unsigned-abs not applied).
  - Signed 0x80000000 / 0xFFFFFFFF: quotient=0x80000000, remainder=0.
- FIX -> DONE. x_rd_value_o is registered on this transition.
- DONE: x_done_o=1.
  - If x_stall_i=1, stay in DONE with x_done_o and x_rd_value_o stable.
  - Else return to IDLE next cycle. x_done_o is high for exactly one unstalled cycle.
- x_rd_value_o holds its last value in IDLE until the next FIX.
- Latency, g_bits_per_cycle=1, start at cycle T:
  - PREP T+1; ITER T+2..T+33; FIX T+34; x_done_o high at T+35.
  - g_bits_per_cycle=2: done at T+19.
  - Fast div0: done at T+3.
- x_kill_i in any state: next state IDLE; x_done_o=0 next cycle; x_rd_value_o unchanged. x_stall_req_o drops in the same cycle, since start is masked and kill forces IDLE.
- Simultaneous kill and start in IDLE: no start.
- Back-to-back: a new start is accepted the cycle after DONE exits (IDLE). No start is accepted in DONE.
- x_valid_i/x_is_divide_i while busy: ignored (the pipeline is stalled by x_stall_req_o).
- Reset asserted mid-operation: immediate return to reset values. No done is produced.

Test Plan:
- DIVU 100/7, start at T -> x_stall_req_o high T..T+34, x_done_o=1 at T+35, x_rd_value_o=14. REMU same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REM 7/-2 -> 1.
- DIV 0x1234/0 with g_fast_div0=1 -> done at T+3, value 0xFFFFFFFF. REM 0x1234/0 -> 0x1234. REMU 0x1234/0 -> 0x1234.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000. REM same operands -> 0. DIVU same operands -> 0.
- Start DIVU 50/5, x_kill_i at T+10 -> IDLE at T+11, no x_done_o. Start DIVU 9/3 at T+11 -> done at T+46, value 3.
- x_stall_i high T+35..T+38 -> x_done_o and value held for 4 cycles, IDLE at T+40. rst_n_i low at T+20 of another op -> all outputs 0 immediately.
